// File: rtl/c3_window_scheduler.sv
// Window scheduler for the LeNet C3 conv/max-pool stage: tracks the raster position of the
// incoming 14x14 C1 stream and emits line-buffer, 5x5 conv-window and 2x2 pool strobes per frame.
module c3_window_scheduler #(
  parameter int IN_W     = 14,
  parameter int IN_H     = 14,
  parameter int K        = 5,
  parameter int CONV_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       lb_wr_en,
  output logic [2:0] lb_wr_row,
  output logic [3:0] lb_wr_col,
  output logic       conv_en,
  output logic [3:0] conv_row,
  output logic [3:0] conv_col,
  output logic       pool_valid,
  output logic [4:0] pool_idx,
  output logic       frame_done,
  output logic       busy,
  output logic       err_overflow
);

  localparam int POOL_W = (IN_W - K + 1) / 2;
  localparam int POOL_H = (IN_H - K + 1) / 2;
  localparam logic [3:0] LAST_COL  = 4'(IN_W - 1);
  localparam logic [3:0] LAST_ROW  = 4'(IN_H - 1);
  localparam logic [3:0] WIN_OFS   = 4'(K - 1);
  localparam logic [2:0] SLOT_LAST = 3'(K - 1);
  localparam logic [4:0] LAST_IDX  = 5'(POOL_W * POOL_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t               state;
  logic [3:0]           row_cnt;
  logic [3:0]           col_cnt;
  logic [2:0]           slot_cnt;
  logic [CONV_LAT-1:0]  pipe_v;
  logic [4:0]           pipe_idx [CONV_LAT];

  logic       accept;
  logic       win;
  logic       tok;
  logic [3:0] win_row;
  logic [3:0] win_col;
  logic [4:0] tok_idx;

  assign in_ready = (state != DRAIN);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign win      = (row_cnt >= WIN_OFS) && (col_cnt >= WIN_OFS);
  assign win_row  = row_cnt - WIN_OFS;
  assign win_col  = col_cnt - WIN_OFS;
  // Only the bottom-right pixel of each 2x2 conv group completes a pool window.
  assign tok      = accept && win && win_row[0] && win_col[0];
  assign tok_idx  = {2'b00, win_row[3:1]} * 5'(POOL_W) + {2'b00, win_col[3:1]};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state        <= IDLE;
      row_cnt      <= '0;
      col_cnt      <= '0;
      slot_cnt     <= '0;
      lb_wr_en     <= 1'b0;
      lb_wr_row    <= '0;
      lb_wr_col    <= '0;
      conv_en      <= 1'b0;
      conv_row     <= '0;
      conv_col     <= '0;
      pool_valid   <= 1'b0;
      pool_idx     <= '0;
      frame_done   <= 1'b0;
      err_overflow <= 1'b0;
      pipe_v       <= '0;
      for (int i = 0; i < CONV_LAT; i++) pipe_idx[i] <= '0;
    end else begin
      lb_wr_en   <= accept;
      conv_en    <= accept && win;
      frame_done <= 1'b0;

      if (in_valid && !in_ready) err_overflow <= 1'b1;

      // Pool tokens model the conv array latency; the output register adds the final cycle.
      pipe_v[0]   <= tok;
      pipe_idx[0] <= tok_idx;
      for (int i = 1; i < CONV_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
      pool_valid <= pipe_v[CONV_LAT-1];
      if (pipe_v[CONV_LAT-1]) pool_idx <= pipe_idx[CONV_LAT-1];

      if (accept) begin
        lb_wr_row <= slot_cnt;
        lb_wr_col <= col_cnt;
        if (win) begin
          conv_row <= win_row;
          conv_col <= win_col;
        end
        if (col_cnt == LAST_COL) begin
          col_cnt <= '0;
          if (row_cnt == LAST_ROW) begin
            row_cnt  <= '0;
            slot_cnt <= '0;
          end else begin
            row_cnt  <= row_cnt + 4'd1;
            slot_cnt <= (slot_cnt == SLOT_LAST) ? 3'd0 : slot_cnt + 3'd1;
          end
        end else begin
          col_cnt <= col_cnt + 4'd1;
        end
      end

      case (state)
        IDLE:  if (accept) state <= FILL;
        FILL:  if (accept && row_cnt == WIN_OFS && col_cnt == 4'd0) state <= RUN;
        RUN:   if (accept && row_cnt == LAST_ROW && col_cnt == LAST_COL) state <= DRAIN;
        DRAIN: begin
          if (pool_valid && pool_idx == LAST_IDX) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
